// File: rtl/window_generator_core.sv
// window_generator_core
//   Streaming sliding-window extractor for raster-order pixels. A chain of
//   WINDOW_SIZE line buffers feeds an N x N column shift register. The packed
//   window and its valid strobe update on the edge that accepts a pixel.
//   Optional feature: define WINDOW_GENERATOR_FRAME_DONE_EN to add a one-cycle
//   frame_done pulse after the last pixel of each frame.

module window_generator_core #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int WINDOW_SIZE = 3,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [PIXEL_WIDTH-1:0]                         pixel_in,
  input  logic                                           pixel_valid,
  output logic [WINDOW_SIZE*WINDOW_SIZE*PIXEL_WIDTH-1:0] window_flat,
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
  output logic                                           frame_done,
`endif
  output logic                                           window_valid
);

  localparam int N  = WINDOW_SIZE;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(N - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(N);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Line buffer storage and the value each buffer presents at the current column.
  logic [PIXEL_WIDTH-1:0]        line_mem [N][WIDTH];
  logic [N-1:0][PIXEL_WIDTH-1:0] tap;

  // Window registers: win[i][j] packs directly onto window_flat.
  logic [N-1:0][N-1:0][PIXEL_WIDTH-1:0] win;

  // Raster position counters: column wraps at WIDTH, row wraps after HEIGHT-1.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Read every line buffer at the current column (pre-write contents).
  // NOTE: every tap is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      tap[k] = line_mem[k][col];
    end
  end

  // Line-buffer chain: new pixel enters buffer 0, each buffer cascades to the next.
  // NOTE: the RAM is intentionally not reset; stale contents only reach
  // windows that window_valid never flags, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line_mem[0][col] <= pixel_in;
      for (int k = 1; k < N; k++) begin
        line_mem[k][col] <= tap[k-1];
      end
    end
  end

  // Window shift: move left one column, load the right column from the taps
  // with the oldest row (buffer N-1) at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (pixel_valid) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][N-1] <= tap[N-1-i];
      end
    end
  end

  assign window_flat = win;

  // Valid only for windows fully inside the frame: N complete rows above and
  // N columns of the current row already seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_valid <= 1'b0;
    end else begin
      window_valid <= pixel_valid && (row >= ROW_MIN) && (col >= COL_MIN);
    end
  end

`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
  // One-cycle pulse after the final pixel of the frame is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pixel_valid && row_last && col_last;
    end
  end
`endif

endmodule

// File: tb/tb_window_generator_core.sv
// tb_window_generator_core
//   Streams a (r+c) mod 256 frame followed by the start of a second frame,
//   then a mid-frame reset and random pixel data, with occasional random
//   stalls. A position-indexed image model supplies the expected windows.

module tb_window_generator_core;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int N  = 3;
  localparam int PW = 8;
  localparam int FW = N * N * PW;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic [FW-1:0] window_flat;
  logic          window_valid;
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
  logic          frame_done;
  int            fd_count;
  logic          exp_fd;
`endif

  window_generator_core #(
    .WIDTH(W), .HEIGHT(H), .WINDOW_SIZE(N), .PIXEL_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .window_flat(window_flat),
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .window_valid(window_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: image written by position, accepted-pixel count since reset.
  logic [PW-1:0] img [H][W];
  int            m_idx;
  logic          exp_valid;
  logic [FW-1:0] exp_flat;
  bit            flat_known;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window whose element [i][j] equals base+i+j (the shape produced by r+c images).
  function automatic logic [FW-1:0] win_of(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        f[(i*N+j)*PW +: PW] = PW'(base + i + j);
    return f;
  endfunction

  // One clock: drive, advance the model on accept, then compare off-edge.
  task automatic cycle(input bit v, input logic [PW-1:0] px);
    int r, c;
    pixel_valid = v;
    pixel_in    = px;
    @(posedge clk);
    if (v) begin
      r = (m_idx / W) % H;
      c = m_idx % W;
      img[r][c] = px;
      m_idx++;
      exp_valid = (r >= N) && (c >= N - 1);
      if (exp_valid) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            exp_flat[(i*N+j)*PW +: PW] = img[r-N+i][c-N+1+j];
        flat_known = 1'b1;
      end else begin
        flat_known = 1'b0;
      end
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
      exp_fd = (r == H - 1) && (c == W - 1);
`endif
    end else begin
      exp_valid = 1'b0;
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
      exp_fd = 1'b0;
`endif
    end
    #1;
    check("window_valid", FW'(window_valid), FW'(exp_valid));
    if (flat_known) check("window_flat", window_flat, exp_flat);
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
    check("frame_done", FW'(frame_done), FW'(exp_fd));
    if (frame_done === 1'b1) fd_count++;
`endif
  endtask

  // Accept one pixel, occasionally preceded by a random stall cycle.
  task automatic push(input logic [PW-1:0] px);
    if ($urandom_range(63) == 0) cycle(1'b0, PW'($urandom));
    cycle(1'b1, px);
  endtask

  task automatic model_reset();
    m_idx      = 0;
    exp_valid  = 1'b0;
    exp_flat   = '0;
    flat_known = 1'b1;
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
    exp_fd     = 1'b0;
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
    fd_count    = 0;
`endif
    model_reset();

    // Reset held for several cycles, then released with no accepts.
    repeat (4) @(posedge clk);
    #1;
    check("reset_valid", FW'(window_valid), '0);
    check("reset_flat", window_flat, '0);
    rst_n = 1'b1;
    cycle(1'b0, 8'hA5);
    check("post_reset_flat", window_flat, '0);

    // Frame 1: pixel(r,c) = (r+c) mod 256.
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        push(PW'(rr + cc));
        if (rr == 3 && cc == 1) check("first_win_early", FW'(window_valid), '0);
        if (rr == 3 && cc == 2) begin
          check("first_win_valid", FW'(window_valid), FW'(1));
          check("first_win_data", window_flat, win_of(0));
        end
        if (rr == 5 && cc < 2) check("left_edge_gated", FW'(window_valid), '0);
        if (rr == 5 && cc == 2) begin
          // Rows 2..4, columns 0..2.
          check("left_edge_valid", FW'(window_valid), FW'(1));
          check("left_edge_data", window_flat, win_of(2));
        end
        if (rr == 10 && cc == 9) begin
          check("interior_a_valid", FW'(window_valid), FW'(1));
          check("interior_a_data", window_flat, win_of(14));
        end
        if (rr == 120 && cc == 159) check("interior_b_data", window_flat, win_of(18));
        if (rr == 50 && cc == 100) begin
          for (int s = 0; s < 5; s++) begin
            cycle(1'b0, PW'($urandom));
            check("stall_valid", FW'(window_valid), '0);
            check("stall_frozen", window_flat, win_of(145));
          end
        end
        if (rr == 50 && cc == 101) begin
          check("resume_valid", FW'(window_valid), FW'(1));
          check("resume_data", window_flat, win_of(146));
        end
      end
    end

    // Frame 2 start: gating restarts at (3,2).
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        push(PW'(rr + cc));
        if (rr == 0 && cc == 0) check("wrap_first_gated", FW'(window_valid), '0);
        if (rr == 3 && cc == 1) check("wrap_early", FW'(window_valid), '0);
        if (rr == 3 && cc == 2) begin
          check("wrap_first_valid", FW'(window_valid), FW'(1));
          check("wrap_first_data", window_flat, win_of(0));
        end
      end
    end
`ifdef WINDOW_GENERATOR_FRAME_DONE_EN
    check("frame_done_count", FW'(fd_count), FW'(1));
`endif

    // Mid-frame asynchronous reset, applied away from a clock edge.
    for (int cc = 0; cc < 7; cc++) push(PW'(5 + cc));
    pixel_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", FW'(window_valid), '0);
    check("async_reset_flat", window_flat, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Restart from (0,0) with random pixel data.
    for (int k = 0; k < 5 * W; k++) begin
      push(PW'($urandom));
      if (k == 3 * W + 1) check("restart_early", FW'(window_valid), '0);
      if (k == 3 * W + 2) check("restart_valid", FW'(window_valid), FW'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
